sad_sram_arbiter: RTL and testbench

Two-requester arbiter for one single-port Sram_Operand instance (A or B operand memory). Requester 0 is the host/loader that fills the operand memory. Requester 1 is the SAD engine that reads it during a computation. It uses round-robin priority with optional burst-length preemption and a one-cycle turnaround on every ownership change, and instantiates once per operand memory.

---
 rtl/sad_sram_arbiter.sv | 79 +++++++
 tb/tb_sad_sram_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sad_sram_arbiter.sv
// sad_sram_arbiter: round-robin two-requester arbiter for one single-port operand SRAM
module sad_sram_arbiter #(
  parameter int A_WIDTH   = 15,
  parameter int D_WIDTH   = 8,
  parameter int MAX_BURST = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Req0,
  input  logic               Req1,
  output logic               Gnt0,
  output logic               Gnt1,
  input  logic [A_WIDTH-1:0] Addr0,
  input  logic [A_WIDTH-1:0] Addr1,
  input  logic [D_WIDTH-1:0] Di0,
  input  logic [D_WIDTH-1:0] Di1,
  input  logic               RW0,
  input  logic               RW1,
  input  logic               En0,
  input  logic               En1,
  output logic [A_WIDTH-1:0] Mem_Addr,
  output logic [D_WIDTH-1:0] Mem_Di,
  output logic               Mem_RW,
  output logic               Mem_En,
  output logic [1:0]         Owner,
  output logic               Preempt
);
  localparam int CW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_BURST);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, TURN} state_t;
  state_t state, state_n, arb;
  logic last_owner, last_owner_n, preempt_n;
  logic own_req, own_en, other_req, preempt_hit;
  logic [CW-1:0] burst_cnt, burst_cnt_n;
  assign arb         = !(Req0 || Req1) ? IDLE : (Req1 && (!Req0 || !last_owner)) ? OWN1 : OWN0;
  assign own_req     = (state == OWN1) ? Req1 : Req0;
  assign own_en      = (state == OWN1) ? En1 : En0;
  assign other_req   = (state == OWN1) ? Req0 : Req1;
  assign preempt_hit = (MAX_BURST > 0) && (burst_cnt == MAX_C) && other_req;
  assign Gnt0        = (state == OWN0);
  assign Gnt1        = (state == OWN1);
  assign Owner       = {Gnt1, Gnt0};
  assign Mem_En      = (Gnt0 && En0) || (Gnt1 && En1);
  assign Mem_RW      = Gnt0 ? RW0 : Gnt1 ? RW1 : 1'b0;
  assign Mem_Addr    = Gnt0 ? Addr0 : Gnt1 ? Addr1 : '0;
  assign Mem_Di      = Gnt0 ? Di0 : Gnt1 ? Di1 : '0;
  // next state: arbitrate from IDLE/TURN, count bursts and release or preempt while owned
  always_comb begin
    state_n      = state;
    last_owner_n = last_owner;
    burst_cnt_n  = burst_cnt;
    preempt_n    = 1'b0;
    if (state == IDLE || state == TURN) begin
      state_n = arb;
      if (arb != IDLE) begin
        last_owner_n = (arb == OWN1);
        burst_cnt_n  = '0;
      end
    end else begin
      if (own_en && burst_cnt != MAX_C) burst_cnt_n = burst_cnt + CW'(1);
      if (!own_req || preempt_hit) state_n = TURN;
      preempt_n = own_req && preempt_hit;
    end
  end
  // state registers; reset leaves last_owner=1 so the host wins the first tie
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      burst_cnt  <= '0;
      Preempt    <= 1'b0;
    end else begin
      state      <= state_n;
      last_owner <= last_owner_n;
      burst_cnt  <= burst_cnt_n;
      Preempt    <= preempt_n;
    end
  end
endmodule

// File: tb/tb_sad_sram_arbiter.sv
// tb_sad_sram_arbiter: scoreboard bench for the operand SRAM arbiter
module tb_sad_sram_arbiter;
  typedef logic [29:0] vec_t;
  typedef struct packed {
    logic rst, r0, r1, e0, e1, g0, g1;
    logic [1:0] own;
    logic pre, men;
    logic [1:0] sel;
  } row_t;
  logic Clk = 1'b0;
  logic Rst = 1'b0, Req0 = 1'b0, Req1 = 1'b0, En0 = 1'b0, En1 = 1'b0;
  logic [14:0] Addr0 = 15'h0005, Addr1 = 15'h0007;
  logic [7:0] Di0 = 8'hA5, Di1 = 8'h3C;
  logic RW0 = 1'b1, RW1 = 1'b0;
  logic Gnt0, Gnt1, Mem_RW, Mem_En, Preempt;
  logic [14:0] Mem_Addr;
  logic [7:0] Mem_Di;
  logic [1:0] Owner;
  logic b_req0 = 1'b0, b_req1 = 1'b0, b_en0 = 1'b0, b_en1 = 1'b0;
  logic b_gnt0, b_gnt1, b_mem_rw, b_mem_en, b_preempt;
  logic [14:0] b_mem_addr;
  logic [7:0] b_mem_di;
  logic [1:0] b_owner;
  int n_cmp = 0, n_err = 0;
  vec_t sb[$];
  logic [4:0] sbb[$];
  row_t stim[$];

  always #5 Clk = ~Clk;

  sad_sram_arbiter #(.A_WIDTH(15), .D_WIDTH(8), .MAX_BURST(4)) u_dut (
    .Clk(Clk), .Rst(Rst), .Req0(Req0), .Req1(Req1), .Gnt0(Gnt0), .Gnt1(Gnt1),
    .Addr0(Addr0), .Addr1(Addr1), .Di0(Di0), .Di1(Di1), .RW0(RW0), .RW1(RW1),
    .En0(En0), .En1(En1), .Mem_Addr(Mem_Addr), .Mem_Di(Mem_Di), .Mem_RW(Mem_RW),
    .Mem_En(Mem_En), .Owner(Owner), .Preempt(Preempt));

  sad_sram_arbiter #(.A_WIDTH(15), .D_WIDTH(8), .MAX_BURST(0)) u_dut0 (
    .Clk(Clk), .Rst(Rst), .Req0(b_req0), .Req1(b_req1), .Gnt0(b_gnt0), .Gnt1(b_gnt1),
    .Addr0(Addr0), .Addr1(Addr1), .Di0(Di0), .Di1(Di1), .RW0(RW0), .RW1(RW1),
    .En0(b_en0), .En1(b_en1), .Mem_Addr(b_mem_addr), .Mem_Di(b_mem_di), .Mem_RW(b_mem_rw),
    .Mem_En(b_mem_en), .Owner(b_owner), .Preempt(b_preempt));

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic vec_t obs();
    return {Gnt0, Gnt1, Owner, Preempt, Mem_En, Mem_RW, Mem_Addr, Mem_Di};
  endfunction

  function automatic vec_t ev(input row_t t);
    logic rw;
    logic [14:0] a;
    logic [7:0] d;
    rw = (t.sel == 2'd1) ? 1'b1 : 1'b0;
    a  = (t.sel == 2'd1) ? 15'h0005 : (t.sel == 2'd2) ? 15'h0007 : 15'h0000;
    d  = (t.sel == 2'd1) ? 8'hA5 : (t.sel == 2'd2) ? 8'h3C : 8'h00;
    return {t.g0, t.g1, t.own, t.pre, t.men, rw, a, d};
  endfunction

  task automatic add(input logic rst, r0, r1, e0, e1, g0, g1, input logic [1:0] own,
                     input logic pre, men, input logic [1:0] sel);
    row_t t;
    t = '{rst, r0, r1, e0, e1, g0, g1, own, pre, men, sel};
    stim.push_back(t);
  endtask

  task automatic drive(input row_t t);
    {Rst, Req0, Req1, En0, En1} = {t.rst, t.r0, t.r1, t.e0, t.e1};
  endtask

  task automatic test_reset();
    vec_t o, e;
    stim.delete();
    add(1,0,0,0,0, 0,0,0,0,0,0);
    add(1,1,1,1,1, 0,0,0,0,0,0);
    foreach (stim[i]) begin
      drive(stim[i]);
      sb.push_back(ev(stim[i]));
      tick();
      o = obs();
      e = sb.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL reset[%0d]: got %h expected %h", i, o, e); end
    end
  endtask

  task automatic test_host_write();
    vec_t o, e;
    stim.delete();
    add(0,1,0,1,0, 1,0,1,0,1,1);
    add(0,1,0,1,0, 1,0,1,0,1,1);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    foreach (stim[i]) begin
      drive(stim[i]);
      sb.push_back(ev(stim[i]));
      tick();
      o = obs();
      e = sb.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL host_write[%0d]: got %h expected %h", i, o, e); end
    end
  endtask

  task automatic test_mux_isolation();
    vec_t o, e;
    stim.delete();
    add(0,1,0,0,1, 1,0,1,0,0,1);
    add(0,1,0,1,1, 1,0,1,0,1,1);
    add(0,0,0,1,1, 0,0,0,0,0,0);
    add(0,0,0,1,1, 0,0,0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    foreach (stim[i]) begin
      drive(stim[i]);
      sb.push_back(ev(stim[i]));
      tick();
      o = obs();
      e = sb.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL mux_isolation[%0d]: got %h expected %h", i, o, e); end
    end
  endtask

  task automatic test_tie_alternate();
    vec_t o, e;
    stim.delete();
    add(1,0,0,0,0, 0,0,0,0,0,0);
    add(0,1,1,0,0, 1,0,1,0,0,1);
    add(0,0,1,0,0, 0,0,0,0,0,0);
    add(0,0,1,0,0, 0,1,2,0,0,2);
    add(0,1,1,0,0, 0,1,2,0,0,2);
    add(0,1,0,0,0, 0,0,0,0,0,0);
    add(0,1,1,0,0, 1,0,1,0,0,1);
    add(0,0,1,0,0, 0,0,0,0,0,0);
    add(0,1,1,0,0, 0,1,2,0,0,2);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    foreach (stim[i]) begin
      drive(stim[i]);
      sb.push_back(ev(stim[i]));
      tick();
      o = obs();
      e = sb.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL tie_alternate[%0d]: got %h expected %h", i, o, e); end
    end
  endtask

  task automatic test_preempt();
    vec_t o, e;
    stim.delete();
    add(0,0,1,0,1, 0,1,2,0,1,2);
    for (int k = 0; k < 4; k++) add(0,1,1,0,1, 0,1,2,0,1,2);
    add(0,1,1,0,1, 0,0,0,1,0,0);
    add(0,1,1,0,1, 1,0,1,0,0,1);
    add(0,1,1,0,1, 1,0,1,0,0,1);
    add(0,0,1,0,1, 0,0,0,0,0,0);
    add(0,0,1,0,1, 0,1,2,0,1,2);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    foreach (stim[i]) begin
      drive(stim[i]);
      sb.push_back(ev(stim[i]));
      tick();
      o = obs();
      e = sb.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL preempt[%0d]: got %h expected %h", i, o, e); end
    end
  endtask

  task automatic test_no_preempt();
    logic [4:0] o, e;
    for (int k = 0; k < 106; k++) begin
      b_req1 = (k < 102);
      b_en1  = (k < 102);
      b_req0 = (k >= 1 && k < 104);
      sbb.push_back(k < 102 ? 5'b01100 : k == 102 ? 5'b00000 : k == 103 ? 5'b10010 : 5'b00000);
      tick();
      o = {b_gnt0, b_gnt1, b_owner, b_preempt};
      e = sbb.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL no_preempt[%0d]: got %b expected %b", k, o, e); end
    end
  endtask

  task automatic test_reset_mid_burst();
    vec_t o, e;
    stim.delete();
    add(0,0,1,0,1, 0,1,2,0,1,2);
    add(0,0,1,0,1, 0,1,2,0,1,2);
    add(1,0,1,0,1, 0,0,0,0,0,0);
    add(0,1,1,0,0, 1,0,1,0,0,1);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    add(0,0,0,0,0, 0,0,0,0,0,0);
    foreach (stim[i]) begin
      drive(stim[i]);
      sb.push_back(ev(stim[i]));
      tick();
      o = obs();
      e = sb.pop_front();
      n_cmp++;
      if (o !== e) begin n_err++; $display("FAIL reset_mid_burst[%0d]: got %h expected %h", i, o, e); end
      if (i == 2) begin
        n_cmp++;
        if (u_dut.burst_cnt !== '0) begin
          n_err++;
          $display("FAIL reset_burst_cnt: got %0d expected 0", u_dut.burst_cnt);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_host_write();
    test_mux_isolation();
    test_tie_alternate();
    test_preempt();
    test_no_preempt();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
